// File: rtl/tm_feeder_pkg.sv
// Shared types and default timing for the Turing machine program feeder.
package tm_feeder_pkg;

  localparam int unsigned DEF_AW        = 6;
  localparam int unsigned DEF_SETUP_LEN = 2;
  localparam int unsigned DEF_PULSE_LEN = 2;
  localparam int unsigned DEF_GAP_LEN   = 3;
  localparam int unsigned TIMER_W       = 8;

  typedef enum logic [1:0] {
    REC_WORD = 2'b00,
    REC_DONE = 2'b01,
    REC_RUN  = 2'b10,
    REC_END  = 2'b11
  } rec_kind_t;

  typedef struct packed {
    rec_kind_t           kind;
    logic [DEF_AW-1:0]   data;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_RUN_CHECK,
    S_FINISH
  } state_t;

  // A phase of len cycles loads len-1; zero-length phases still last one cycle.
  function automatic logic [TIMER_W-1:0] timer_load(input int unsigned len);
    return (len <= 1) ? '0 : TIMER_W'(len - 1);
  endfunction

endpackage

// File: rtl/tm_feeder_timer.sv
// Loadable down-counter with zero flag; times the SETUP/PULSE/GAP phases.
module tm_feeder_timer
  import tm_feeder_pkg::*;
#(
  parameter int unsigned W = TIMER_W
)(
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load takes priority; otherwise count down and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tm_program_feeder.sv
// Replays a stored record list into the Turing machine's Next/Done/input_data
// entry protocol. Optional macro TM_FEEDER_STEP_LIMIT_EN adds a RUN step limit
// (MAX_STEPS) and the sticky step_limit_hit output.
module tm_program_feeder
  import tm_feeder_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned SETUP_LEN = DEF_SETUP_LEN,
  parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
  parameter int unsigned GAP_LEN   = DEF_GAP_LEN
`ifdef TM_FEEDER_STEP_LIMIT_EN
  ,parameter int unsigned MAX_STEPS = 255
`endif
)(
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      prog_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] prog_addr,
  input  logic [AW+1:0]                             prog_wdata,
  input  logic                                      start,
  input  logic                                      compute_done,
  output logic [AW-1:0]                             input_data,
  output logic                                      next,
  output logic                                      done,
  output logic                                      busy,
  output logic                                      finished,
  output logic [15:0]                               step_count
`ifdef TM_FEEDER_STEP_LIMIT_EN
  ,output logic                                     step_limit_hit
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [TIMER_W-1:0] SETUP_LD = timer_load(SETUP_LEN);
  localparam logic [TIMER_W-1:0] PULSE_LD = timer_load(PULSE_LEN);
  localparam logic [TIMER_W-1:0] GAP_LD   = timer_load(GAP_LEN);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  rec_kind_t           kind_q, kind_d;
  logic [AW-1:0]       data_q, data_d;
  logic [15:0]         step_q, step_d;
  logic [AW+1:0]       rec_q [DEPTH];
  logic [AW+1:0]       fetched;
  rec_kind_t           fetch_kind;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_zero;
`ifdef TM_FEEDER_STEP_LIMIT_EN
  logic                hit_q, hit_d;
`endif

  assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign finished = (state_q == S_FINISH);
  assign next     = (state_q == S_PULSE) && (kind_q != REC_DONE);
  assign done     = (state_q == S_PULSE) && (kind_q == REC_DONE);
  assign input_data = data_q;
  assign step_count = step_q;
`ifdef TM_FEEDER_STEP_LIMIT_EN
  assign step_limit_hit = hit_q;
`endif

  assign fetched    = rec_q[ptr_q];
  assign fetch_kind = rec_kind_t'(fetched[AW +: 2]);

  // Record storage: written only while idle/finished, never reset.
  always_ff @(posedge clock) begin
    if (prog_we && !busy && (32'(prog_addr) < DEPTH)) begin
      rec_q[prog_addr] <= prog_wdata;
    end
  end

  tm_feeder_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state logic: sequences records and loads the shared phase timer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    kind_d   = kind_q;
    data_d   = data_q;
    step_d   = step_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef TM_FEEDER_STEP_LIMIT_EN
    hit_d    = hit_q;
`endif
    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d = S_FETCH;
          ptr_d   = '0;
          step_d  = '0;
`ifdef TM_FEEDER_STEP_LIMIT_EN
          hit_d   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        kind_d = fetch_kind;
        unique case (fetch_kind)
          REC_WORD: begin
            data_d   = fetched[AW-1:0];
            state_d  = S_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end
          REC_DONE: begin
            state_d  = S_PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end
          REC_RUN:  state_d = S_RUN_CHECK;
          REC_END:  state_d = S_FINISH;
          default:  state_d = S_FINISH;
        endcase
      end
      S_SETUP: begin
        if (tmr_zero) begin
          state_d  = S_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      S_PULSE: begin
        if (tmr_zero) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          if (kind_q == REC_RUN) begin
            state_d = S_RUN_CHECK;
          end else if (ptr_q == LAST_PTR) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + PW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_RUN_CHECK: begin
        if (compute_done) begin
          if (ptr_q == LAST_PTR) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + PW'(1);
            state_d = S_FETCH;
          end
`ifdef TM_FEEDER_STEP_LIMIT_EN
        end else if (step_q == 16'(MAX_STEPS)) begin
          state_d = S_FINISH;
          hit_d   = 1'b1;
`endif
        end else begin
          state_d  = S_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          if (step_q != '1) begin
            step_d = step_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      kind_q  <= REC_WORD;
      data_q  <= '0;
      step_q  <= '0;
`ifdef TM_FEEDER_STEP_LIMIT_EN
      hit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
      step_q  <= step_d;
`ifdef TM_FEEDER_STEP_LIMIT_EN
      hit_q   <= hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_tm_program_feeder.sv
// Directed bench for tm_program_feeder (cycle-exact protocol checks).
module tb_tm_program_feeder;

  localparam logic [1:0] K_WORD = 2'b00;
  localparam logic [1:0] K_DONE = 2'b01;
  localparam logic [1:0] K_RUN  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [7:0]  prog_wdata = '0;
  logic        start = 1'b0;
  logic        compute_done = 1'b0;
  logic [5:0]  input_data;
  logic        next;
  logic        done;
  logic        busy;
  logic        finished;
  logic [15:0] step_count;
`ifdef TM_FEEDER_STEP_LIMIT_EN
  logic        step_limit_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

`ifdef TM_FEEDER_STEP_LIMIT_EN
  tm_program_feeder #(.AW(6), .DEPTH(32), .MAX_STEPS(10)) dut (
`else
  tm_program_feeder #(.AW(6), .DEPTH(32)) dut (
`endif
    .clock        (clock),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .start        (start),
    .compute_done (compute_done),
    .input_data   (input_data),
    .next         (next),
    .done         (done),
    .busy         (busy),
    .finished     (finished),
    .step_count   (step_count)
`ifdef TM_FEEDER_STEP_LIMIT_EN
    ,.step_limit_hit (step_limit_hit)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wr(input int unsigned addr, input logic [1:0] kind, input logic [5:0] data);
    prog_we    = 1'b1;
    prog_addr  = 5'(addr);
    prog_wdata = {kind, data};
    step();
    prog_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // FETCH (1), SETUP (2), PULSE next (2), GAP (3)
  task automatic word_seq(input logic [5:0] d);
    chk("word_fetch_busy", busy, 1);
    chk("word_fetch_next", next, 0);
    step();
    repeat (2) begin
      chk("word_setup_next", next, 0);
      chk("word_setup_data", input_data, d);
      step();
    end
    repeat (2) begin
      chk("word_pulse_next", next, 1);
      chk("word_pulse_done", done, 0);
      chk("word_pulse_data", input_data, d);
      step();
    end
    repeat (3) begin
      chk("word_gap_next", next, 0);
      chk("word_gap_data", input_data, d);
      step();
    end
  endtask

  // FETCH (1), PULSE done (2), GAP (3)
  task automatic done_seq(input logic [5:0] d);
    chk("done_fetch_done", done, 0);
    step();
    repeat (2) begin
      chk("done_pulse_done", done, 1);
      chk("done_pulse_next", next, 0);
      chk("done_pulse_data", input_data, d);
      step();
    end
    repeat (3) begin
      chk("done_gap_done", done, 0);
      step();
    end
  endtask

  // RUN record; compute_done rises during the gap after pulse n
  task automatic run_seq(input int n, input logic [5:0] d);
    chk("run_fetch_next", next, 0);
    step();
    for (int i = 1; i <= n; i++) begin
      chk("run_check_next", next, 0);
      step();
      repeat (2) begin
        chk("run_pulse_next", next, 1);
        chk("run_pulse_data", input_data, d);
        chk("run_step_count", step_count, 32'(i));
        step();
      end
      for (int g = 0; g < 3; g++) begin
        if (i == n && g == 0) compute_done = 1'b1;
        chk("run_gap_next", next, 0);
        step();
      end
    end
    chk("run_final_check_next", next, 0);
    step();
    compute_done = 1'b0;
  endtask

  task automatic end_seq(input int steps);
    chk("end_fetch_busy", busy, 1);
    step();
    chk("end_finished", finished, 1);
    chk("end_busy", busy, 0);
    chk("end_next", next, 0);
    chk("end_done", done, 0);
    chk("end_step_count", step_count, 32'(steps));
  endtask

  // Protocol invariants checked every cycle outside reset.
  logic       prev_next = 1'b0;
  logic [5:0] prev_data = '0;
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert (!(next && done)) else begin
        errors++;
        $error("FAIL next_done_excl: next=%b done=%b expected not both", next, done);
      end
      if (prev_next && next) begin
        checks++;
        assert (input_data === prev_data) else begin
          errors++;
          $error("FAIL data_stable_in_pulse: observed %0h expected %0h", input_data, prev_data);
        end
      end
    end
    prev_next <= next;
    prev_data <= input_data;
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_next", next, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_data", input_data, 0);
    chk("rst_steps", step_count, 0);
    reset = 1'b0;
    step();

    // 1: WORD 3, WORD 5, DONE, END (END written in the same cycle as start)
    wr(0, K_WORD, 6'd3);
    wr(1, K_WORD, 6'd5);
    wr(2, K_DONE, 6'd0);
    prog_we = 1'b1; prog_addr = 5'd3; prog_wdata = {K_END, 6'd0};
    start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    word_seq(6'd3);
    word_seq(6'd5);
    done_seq(6'd5);
    end_seq(0);

    // 2: RUN until compute_done after the 4th pulse
    wr(0, K_WORD, 6'd7);
    wr(1, K_RUN, 6'd0);
    wr(2, K_END, 6'd0);
    pulse_start();
    word_seq(6'd7);
    run_seq(4, 6'd7);
    end_seq(4);

    // 3: all 32 records WORD, finish via pointer wrap
    for (int i = 0; i < 32; i++) wr(i, K_WORD, 6'(i));
    pulse_start();
    for (int i = 0; i < 32; i++) word_seq(6'(i));
    chk("wrap_finished", finished, 1);
    chk("wrap_busy", busy, 0);
    chk("wrap_next", next, 0);

    // 4: start/prog_we ignored while busy; reset during PULSE
    pulse_start();
    word_seq(6'd0);
    prog_we = 1'b1; prog_addr = 5'd2; prog_wdata = {K_WORD, 6'd50};
    start = 1'b1;
    word_seq(6'd1);
    prog_we = 1'b0; start = 1'b0;
    word_seq(6'd2);
    chk("rp_fetch_busy", busy, 1);
    step();
    repeat (2) step();
    chk("rp_in_pulse", next, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rp_next_dropped", next, 0);
    chk("rp_busy", busy, 0);
    chk("rp_finished", finished, 0);
    chk("rp_data", input_data, 0);
    pulse_start();
    word_seq(6'd0);
    word_seq(6'd1);
    word_seq(6'd2);
    word_seq(6'd3);

`ifdef TM_FEEDER_STEP_LIMIT_EN
    // 5: step limit of 10 with compute_done held low
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr(0, K_WORD, 6'd9);
    wr(1, K_RUN, 6'd0);
    wr(2, K_END, 6'd0);
    pulse_start();
    word_seq(6'd9);
    chk("lim_fetch_next", next, 0);
    step();
    for (int i = 1; i <= 10; i++) begin
      chk("lim_check_next", next, 0);
      step();
      repeat (2) begin
        chk("lim_pulse_next", next, 1);
        chk("lim_step_count", step_count, 32'(i));
        step();
      end
      repeat (3) step();
    end
    chk("lim_last_check_next", next, 0);
    step();
    chk("lim_finished", finished, 1);
    chk("lim_hit", step_limit_hit, 1);
    chk("lim_steps", step_count, 10);
    chk("lim_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
